// File: rtl/itlb_refill_ctrl.sv
// ITLB refill controller: takes one fetch miss at a time, obtains a PLRU victim,
// issues a single page-table walk and writes the translation into the victim
// entry or reports an instruction page fault. An sfence flush may abort the
// refill at any point; a walk already accepted by the PTW is drained first.
module itlb_refill_ctrl #(
  parameter int ENTRIES = 32,
  parameter int VPN_W   = 27,
  parameter int PPN_W   = 44,
  parameter int PERM_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               miss_vld_i,
  input  logic [VPN_W-1:0]   miss_vpn_i,
  output logic               miss_rdy_o,
  input  logic               flush_i,
  output logic               plru_refill_rq_o,
  input  logic [ENTRIES-1:0] plru_victim_onehot_i,
  output logic               plru_refill_vld_o,
  output logic               ptw_req_vld_o,
  input  logic               ptw_req_rdy_i,
  output logic [VPN_W-1:0]   ptw_req_vpn_o,
  input  logic               ptw_resp_vld_i,
  input  logic [PPN_W-1:0]   ptw_resp_ppn_i,
  input  logic [PERM_W-1:0]  ptw_resp_perm_i,
  input  logic               ptw_resp_fault_i,
  output logic               tlb_wr_en_o,
  output logic [ENTRIES-1:0] tlb_wr_onehot_o,
  output logic [VPN_W-1:0]   tlb_wr_vpn_o,
  output logic [PPN_W-1:0]   tlb_wr_ppn_o,
  output logic [PERM_W-1:0]  tlb_wr_perm_o,
  output logic               refill_done_o,
  output logic               refill_fault_o,
  output logic               busy_o,
  output logic [CNT_W-1:0]   miss_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VICTIM,
    S_PTW_REQ,
    S_PTW_WAIT,
    S_WRITE,
    S_FAULT,
    S_DRAIN
  } state_t;

  state_t              state_q;
  logic                rq_q;
  logic                req_vld_q;
  logic                wr_q;
  logic                fault_q;
  logic                first_q;
  logic [VPN_W-1:0]    vpn_q;
  logic [PPN_W-1:0]    ppn_q;
  logic [PERM_W-1:0]   perm_q;
  logic [ENTRIES-1:0]  onehot_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                accept;

  // Miss counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // A miss is only taken while idle and no flush is being applied.
  assign miss_rdy_o = (state_q == S_IDLE) && !flush_i;
  assign accept     = miss_vld_i && miss_rdy_o;

  // Refill sequencer: state, registered strobes and latched miss/walk data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      rq_q      <= 1'b0;
      req_vld_q <= 1'b0;
      wr_q      <= 1'b0;
      fault_q   <= 1'b0;
      first_q   <= 1'b0;
      vpn_q     <= '0;
      ppn_q     <= '0;
      perm_q    <= '0;
      onehot_q  <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            vpn_q   <= miss_vpn_i;
            cnt_q   <= sat_inc(cnt_q);
            rq_q    <= 1'b1;
            state_q <= S_VICTIM;
          end
        end
        S_VICTIM: begin
          rq_q <= 1'b0;
          if (flush_i) begin
            state_q <= S_IDLE;
          end else begin
            req_vld_q <= 1'b1;
            first_q   <= 1'b1;
            state_q   <= S_PTW_REQ;
          end
        end
        S_PTW_REQ: begin
          // The PLRU victim is only guaranteed valid on the first request cycle.
          first_q <= 1'b0;
          if (first_q) onehot_q <= plru_victim_onehot_i;
          if (ptw_req_rdy_i) begin
            req_vld_q <= 1'b0;
            state_q   <= flush_i ? S_DRAIN : S_PTW_WAIT;
          end else if (flush_i) begin
            req_vld_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_PTW_WAIT: begin
          if (ptw_resp_vld_i) begin
            if (flush_i) begin
              state_q <= S_IDLE;
            end else begin
              ppn_q  <= ptw_resp_ppn_i;
              perm_q <= ptw_resp_perm_i;
              if (ptw_resp_fault_i) begin
                fault_q <= 1'b1;
                state_q <= S_FAULT;
              end else begin
                wr_q    <= 1'b1;
                state_q <= S_WRITE;
              end
            end
          end else if (flush_i) begin
            state_q <= S_DRAIN;
          end
        end
        S_WRITE: begin
          wr_q    <= 1'b0;
          state_q <= S_IDLE;
        end
        S_FAULT: begin
          fault_q <= 1'b0;
          state_q <= S_IDLE;
        end
        S_DRAIN: begin
          if (ptw_resp_vld_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A flush arriving in the write/fault cycle cancels the completion strobes.
  assign tlb_wr_en_o       = wr_q && !flush_i;
  assign plru_refill_vld_o = wr_q && !flush_i;
  assign refill_done_o     = wr_q && !flush_i;
  assign refill_fault_o    = fault_q && !flush_i;

  assign plru_refill_rq_o = rq_q;
  assign ptw_req_vld_o    = req_vld_q;
  assign ptw_req_vpn_o    = vpn_q;
  assign tlb_wr_onehot_o  = onehot_q;
  assign tlb_wr_vpn_o     = vpn_q;
  assign tlb_wr_ppn_o     = ppn_q;
  assign tlb_wr_perm_o    = perm_q;
  assign busy_o           = (state_q != S_IDLE);
  assign miss_cnt_o       = cnt_q;

endmodule

// File: tb/tb_itlb_refill_ctrl.sv
// Directed bench for itlb_refill_ctrl. Each record holds one cycle of inputs and
// the outputs expected during that cycle. The miss counter is instantiated
// narrow so its saturation point is reachable in a short run.
module tb_itlb_refill_ctrl;

  localparam int ENTRIES = 32;
  localparam int VPN_W   = 27;
  localparam int PPN_W   = 44;
  localparam int PERM_W  = 8;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = 63;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               miss_vld_i;
  logic [VPN_W-1:0]   miss_vpn_i;
  logic               miss_rdy_o;
  logic               flush_i;
  logic               plru_refill_rq_o;
  logic [ENTRIES-1:0] plru_victim_onehot_i;
  logic               plru_refill_vld_o;
  logic               ptw_req_vld_o;
  logic               ptw_req_rdy_i;
  logic [VPN_W-1:0]   ptw_req_vpn_o;
  logic               ptw_resp_vld_i;
  logic [PPN_W-1:0]   ptw_resp_ppn_i;
  logic [PERM_W-1:0]  ptw_resp_perm_i;
  logic               ptw_resp_fault_i;
  logic               tlb_wr_en_o;
  logic [ENTRIES-1:0] tlb_wr_onehot_o;
  logic [VPN_W-1:0]   tlb_wr_vpn_o;
  logic [PPN_W-1:0]   tlb_wr_ppn_o;
  logic [PERM_W-1:0]  tlb_wr_perm_o;
  logic               refill_done_o;
  logic               refill_fault_o;
  logic               busy_o;
  logic [CNT_W-1:0]   miss_cnt_o;

  int checks   = 0;
  int failures = 0;
  int cnt_e;

  itlb_refill_ctrl #(
    .ENTRIES(ENTRIES), .VPN_W(VPN_W), .PPN_W(PPN_W), .PERM_W(PERM_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .miss_vld_i(miss_vld_i), .miss_vpn_i(miss_vpn_i), .miss_rdy_o(miss_rdy_o),
    .flush_i(flush_i),
    .plru_refill_rq_o(plru_refill_rq_o), .plru_victim_onehot_i(plru_victim_onehot_i),
    .plru_refill_vld_o(plru_refill_vld_o),
    .ptw_req_vld_o(ptw_req_vld_o), .ptw_req_rdy_i(ptw_req_rdy_i), .ptw_req_vpn_o(ptw_req_vpn_o),
    .ptw_resp_vld_i(ptw_resp_vld_i), .ptw_resp_ppn_i(ptw_resp_ppn_i),
    .ptw_resp_perm_i(ptw_resp_perm_i), .ptw_resp_fault_i(ptw_resp_fault_i),
    .tlb_wr_en_o(tlb_wr_en_o), .tlb_wr_onehot_o(tlb_wr_onehot_o), .tlb_wr_vpn_o(tlb_wr_vpn_o),
    .tlb_wr_ppn_o(tlb_wr_ppn_o), .tlb_wr_perm_o(tlb_wr_perm_o),
    .refill_done_o(refill_done_o), .refill_fault_o(refill_fault_o),
    .busy_o(busy_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // ctl bit order: {miss_rdy, plru_rq, ptw_req_vld, wr_en, plru_vld, done, fault, busy}
  typedef struct {
    logic               rst;
    logic               mv;
    logic [VPN_W-1:0]   vpn;
    logic               fl;
    logic [ENTRIES-1:0] vic;
    logic               rdy;
    logic               rv;
    logic [PPN_W-1:0]   ppn;
    logic [PERM_W-1:0]  perm;
    logic               flt;
    logic [7:0]         ctl;
    int                 cnt;
    logic [ENTRIES-1:0] d_oh;
    logic [VPN_W-1:0]   d_vpn;
    logic [PPN_W-1:0]   d_ppn;
    logic [PERM_W-1:0]  d_perm;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic mv, input logic [VPN_W-1:0] vpn, input logic fl,
                              input logic [ENTRIES-1:0] vic, input logic rdy, input logic rv,
                              input logic [PPN_W-1:0] ppn, input logic [PERM_W-1:0] perm,
                              input logic flt, input logic [7:0] ctl, input int cnt,
                              input logic [ENTRIES-1:0] d_oh, input logic [VPN_W-1:0] d_vpn,
                              input logic [PPN_W-1:0] d_ppn, input logic [PERM_W-1:0] d_perm);
    vec_t v;
    v.rst = 1'b0; v.mv = mv; v.vpn = vpn; v.fl = fl; v.vic = vic; v.rdy = rdy;
    v.rv = rv; v.ppn = ppn; v.perm = perm; v.flt = flt; v.ctl = ctl; v.cnt = cnt;
    v.d_oh = d_oh; v.d_vpn = d_vpn; v.d_ppn = d_ppn; v.d_perm = d_perm;
    return v;
  endfunction

  function automatic logic [7:0] ctl_now();
    return {miss_rdy_o, plru_refill_rq_o, ptw_req_vld_o, tlb_wr_en_o,
            plru_refill_vld_o, refill_done_o, refill_fault_o, busy_o};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge, check outputs mid-cycle.
  task automatic run_vec(input vec_t v, input string nm);
    @(posedge clk_i); #1;
    rst_i = v.rst; miss_vld_i = v.mv; miss_vpn_i = v.vpn; flush_i = v.fl;
    plru_victim_onehot_i = v.vic; ptw_req_rdy_i = v.rdy; ptw_resp_vld_i = v.rv;
    ptw_resp_ppn_i = v.ppn; ptw_resp_perm_i = v.perm; ptw_resp_fault_i = v.flt;
    @(negedge clk_i);
    chk({nm, "_ctl"}, ctl_now(), v.ctl);
    chk({nm, "_cnt"}, miss_cnt_o, v.cnt);
    if (v.ctl[5]) chk({nm, "_reqvpn"}, ptw_req_vpn_o, v.d_vpn);
    if (v.ctl[4]) begin
      chk({nm, "_wroh"}, tlb_wr_onehot_o, v.d_oh);
      chk({nm, "_wrvpn"}, tlb_wr_vpn_o, v.d_vpn);
      chk({nm, "_wrppn"}, tlb_wr_ppn_o, v.d_ppn);
      chk({nm, "_wrperm"}, tlb_wr_perm_o, v.d_perm);
    end
  endtask

  initial begin
    rst_i = 1'b1; miss_vld_i = 1'b0; miss_vpn_i = '0; flush_i = 1'b0;
    plru_victim_onehot_i = '0; ptw_req_rdy_i = 1'b0; ptw_resp_vld_i = 1'b0;
    ptw_resp_ppn_i = '0; ptw_resp_perm_i = '0; ptw_resp_fault_i = 1'b0;

    // Basic refill
    tv.push_back(mk(1, 'h1234, 0, 0,           0, 0, 0,     0,    0, 8'h80, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      0, 0,           0, 0, 0,     0,    0, 8'h41, 1, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      0, 'h100,       1, 0, 0,     0,    0, 8'h21, 1, 0, 'h1234, 0, 0));
    tv.push_back(mk(0, 0,      0, 'hFFFFFFFF,  0, 1, 'hABC, 'hCB, 0, 8'h01, 1, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      0, 0,           0, 0, 0,     0,    0, 8'h1D, 1, 'h100, 'h1234, 'hABC, 'hCB));
    tv.push_back(mk(0, 0,      0, 0,           0, 0, 0,     0,    0, 8'h80, 1, 0, 0, 0, 0));
    // Walk ending in a fault
    tv.push_back(mk(1, 'h20000, 0, 0,   0, 0, 0,    0,    0, 8'h80, 1, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,       0, 0,   0, 0, 0,    0,    0, 8'h41, 2, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,       0, 'h1, 1, 0, 0,    0,    0, 8'h21, 2, 0, 'h20000, 0, 0));
    tv.push_back(mk(0, 0,       0, 0,   0, 1, 'h77, 'h01, 1, 8'h01, 2, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,       0, 0,   0, 0, 0,    0,    0, 8'h03, 2, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,       0, 0,   0, 0, 0,    0,    0, 8'h80, 2, 0, 0, 0, 0));
    // Flush while waiting for the walk: drain until the response
    tv.push_back(mk(1, 'h3333, 0, 0,   0, 0, 0,    0,    0, 8'h80, 2, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      0, 0,   0, 0, 0,    0,    0, 8'h41, 3, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      0, 'h8, 1, 0, 0,    0,    0, 8'h21, 3, 0, 'h3333, 0, 0));
    tv.push_back(mk(0, 0,      1, 0,   0, 0, 0,    0,    0, 8'h01, 3, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      1, 0,   0, 0, 0,    0,    0, 8'h01, 3, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      0, 0,   0, 0, 0,    0,    0, 8'h01, 3, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      0, 0,   0, 0, 0,    0,    0, 8'h01, 3, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      0, 0,   0, 1, 'h55, 'hCB, 0, 8'h01, 3, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      0, 0,   0, 0, 0,    0,    0, 8'h80, 3, 0, 0, 0, 0));
    // Flush together with the PTW handshake
    tv.push_back(mk(1, 'h4444, 0, 0,   0, 0, 0,    0,    0, 8'h80, 3, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      0, 0,   0, 0, 0,    0,    0, 8'h41, 4, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      1, 'h2, 1, 0, 0,    0,    0, 8'h21, 4, 0, 'h4444, 0, 0));
    tv.push_back(mk(0, 0,      0, 0,   0, 0, 0,    0,    0, 8'h01, 4, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      0, 0,   0, 1, 'h12, 'hCB, 0, 8'h01, 4, 0, 0, 0, 0));
    // Flush and miss together in IDLE, then a clean miss; stray response ignored
    tv.push_back(mk(1, 'h5555, 1, 0,   0, 0, 0,    0,    0, 8'h00, 4, 0, 0, 0, 0));
    tv.push_back(mk(1, 'h5555, 0, 0,   0, 0, 0,    0,    0, 8'h80, 4, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      1, 0,   0, 0, 0,    0,    0, 8'h41, 5, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      0, 0,   0, 1, 'h66, 'hCB, 0, 8'h80, 5, 0, 0, 0, 0));
    // Flush in PTW_REQ without handshake
    tv.push_back(mk(1, 'h6666, 0, 0,   0, 0, 0,    0,    0, 8'h80, 5, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      0, 0,   0, 0, 0,    0,    0, 8'h41, 6, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      1, 'h4, 0, 0, 0,    0,    0, 8'h21, 6, 0, 'h6666, 0, 0));
    tv.push_back(mk(0, 0,      0, 0,   0, 0, 0,    0,    0, 8'h80, 6, 0, 0, 0, 0));
    // Flush in the WRITE cycle suppresses the strobes
    tv.push_back(mk(1, 'h7777, 0, 0,   0, 0, 0,    0,    0, 8'h80, 6, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      0, 0,   0, 0, 0,    0,    0, 8'h41, 7, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      0, 'h4, 1, 0, 0,    0,    0, 8'h21, 7, 0, 'h7777, 0, 0));
    tv.push_back(mk(0, 0,      0, 0,   0, 1, 'h99, 'hCF, 0, 8'h01, 7, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      1, 0,   0, 0, 0,    0,    0, 8'h01, 7, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      0, 0,   0, 0, 0,    0,    0, 8'h80, 7, 0, 0, 0, 0));
    // Flush with the response in PTW_WAIT: discarded, straight to IDLE
    tv.push_back(mk(1, 'h8888, 0, 0,   0, 0, 0,    0,    0, 8'h80, 7, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      0, 0,   0, 0, 0,    0,    0, 8'h41, 8, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      0, 'h1, 1, 0, 0,    0,    0, 8'h21, 8, 0, 'h8888, 0, 0));
    tv.push_back(mk(0, 0,      1, 0,   0, 1, 'hAA, 'hCB, 0, 8'h01, 8, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      0, 0,   0, 0, 0,    0,    0, 8'h80, 8, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,      0, 0,   0, 0, 0,    0,    0, 8'h80, 8, 0, 0, 0, 0));

    // Reset state
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset_ctl", ctl_now(), 8'h80);
    chk("reset_cnt", miss_cnt_o, 0);
    chk("reset_wroh", tlb_wr_onehot_o, 0);
    chk("reset_reqvpn", ptw_req_vpn_o, 0);

    foreach (tv[i]) run_vec(tv[i], $sformatf("vec%0d", i));

    // PTW backpressure: request held stable, victim taken from the first cycle only
    cnt_e = 8;
    run_vec(mk(1, 'hABCDE, 0, 0, 0, 0, 0, 0, 0, 8'h80, cnt_e, 0, 0, 0, 0), "bp_acc");
    cnt_e = 9;
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h41, cnt_e, 0, 0, 0, 0), "bp_vic");
    for (int k = 0; k < 6; k++)
      run_vec(mk(0, 0, 0, (k == 0) ? 32'h10 : 32'h20000, (k == 5), 0, 0, 0, 0,
                 8'h21, cnt_e, 0, 'hABCDE, 0, 0), $sformatf("bp_req%0d", k));
    run_vec(mk(0, 0, 0, 0, 0, 1, 'h123, 'hCB, 0, 8'h01, cnt_e, 0, 0, 0, 0), "bp_wait");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h1D, cnt_e, 'h10, 'hABCDE, 'h123, 'hCB), "bp_wr");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h80, cnt_e, 0, 0, 0, 0), "bp_idle");

    // Counter saturation: accept, abort in VICTIM, repeat past the top
    for (int k = 0; k < 60; k++) begin
      run_vec(mk(1, k, 0, 0, 0, 0, 0, 0, 0, 8'h80, cnt_e, 0, 0, 0, 0), "sat_acc");
      cnt_e = (cnt_e == CNT_MAX) ? CNT_MAX : cnt_e + 1;
      run_vec(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h41, cnt_e, 0, 0, 0, 0), "sat_vic");
    end
    chk("cnt_saturated", miss_cnt_o, CNT_MAX);

    // Reset during PTW_WAIT abandons the walk and clears everything
    run_vec(mk(1, 'h9999, 0, 0, 0, 0, 0, 0, 0, 8'h80, CNT_MAX, 0, 0, 0, 0), "rst_acc");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h41, CNT_MAX, 0, 0, 0, 0), "rst_vic");
    run_vec(mk(0, 0, 0, 'h80000000, 1, 0, 0, 0, 0, 8'h21, CNT_MAX, 0, 'h9999, 0, 0), "rst_req");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h01, CNT_MAX, 0, 0, 0, 0), "rst_wait");
    rst_i = 1'b1;
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h80, 0, 0, 0, 0, 0), "rst_after");
    chk("rst_wroh", tlb_wr_onehot_o, 0);
    chk("rst_wrvpn", tlb_wr_vpn_o, 0);
    chk("rst_wrppn", tlb_wr_ppn_o, 0);
    chk("rst_wrperm", tlb_wr_perm_o, 0);
    chk("rst_reqvpn", ptw_req_vpn_o, 0);
    run_vec(mk(0, 0, 0, 0, 0, 1, 'h5A, 'hCB, 0, 8'h80, 0, 0, 0, 0, 0), "rst_stray");
    run_vec(mk(1, 'h1111, 0, 0, 0, 0, 0, 0, 0, 8'h80, 0, 0, 0, 0, 0), "post_acc");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h41, 1, 0, 0, 0, 0), "post_vic");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/itlb_refill_ctrl.md
Name: itlb_refill_ctrl

Overview:
Sequences an ITLB miss from the fetch unit through to a completed TLB refill:
- asks the 32-entry PLRU replacement block for a victim slot;
- issues a single page-table-walk request and waits for its response;
- writes the translated entry into the victim slot, or reports a page fault back to fetch.

The block sits between the fetch stage, the ITLB array with its PLRU, and the PTW arbiter. It holds at most one miss in flight and supports an sfence-style flush at any point.

Parameters:
ENTRIES, 32, number of ITLB entries; width of the victim/write one-hot vectors.
VPN_W, 27, virtual page number width (Sv39).
PPN_W, 44, physical page number width.
PERM_W, 8, PTE permission/attribute bits (V,R,W,X,U,G,A,D).
CNT_W, 16, miss statistics counter width.

Ports:
clk_i  in  1  clock; one clock domain.
rst_i  in  1  reset, synchronous, active-high.
miss_vld_i  in  1  fetch reports an ITLB miss.
miss_vpn_i  in  VPN_W  VPN that missed.
miss_rdy_o  out  1  controller can accept a miss (high only in IDLE, and not while flush_i is high).
flush_i  in  1  sfence/ASID flush; aborts the refill in flight.
plru_refill_rq_o  out  1  one-cycle request for the PLRU to register its victim index.
plru_victim_onehot_i  in  ENTRIES  PLRU victim one-hot; valid from the cycle after plru_refill_rq_o.
plru_refill_vld_o  out  1  tells the PLRU the victim has been filled (updates its tree).
ptw_req_vld_o  out  1  PTW request valid.
ptw_req_rdy_i  in  1  PTW accepts the request.
ptw_req_vpn_o  out  VPN_W  VPN to walk.
ptw_resp_vld_i  in  1  PTW response valid (one-cycle pulse).
ptw_resp_ppn_i  in  PPN_W  translated PPN.
ptw_resp_perm_i  in  PERM_W  PTE permissions.
ptw_resp_fault_i  in  1  walk ended in a page/access fault.
tlb_wr_en_o  out  1  ITLB entry write strobe.
tlb_wr_onehot_o  out  ENTRIES  entry to write.
tlb_wr_vpn_o  out  VPN_W  tag to write.
tlb_wr_ppn_o  out  PPN_W  PPN to write.
tlb_wr_perm_o  out  PERM_W  permissions to write.
refill_done_o  out  1  one-cycle pulse: refill complete; fetch replays.
refill_fault_o  out  1  one-cycle pulse: instruction page fault for the latched VPN.
busy_o  out  1  state is not IDLE.
miss_cnt_o  out  CNT_W  count of accepted misses, saturating.

Behaviour:
- Reset (rst_i sampled high at clk_i edge):
  - state goes to IDLE and miss_cnt_o=0;
  - all latched VPN/PPN/perm/onehot registers are cleared to 0;
  - every strobe, valid and pulse output is 0; miss_rdy_o=1 once rst_i is low.
  - Reset mid-operation abandons the walk; no PTW response is expected after reset.
- States: IDLE, VICTIM, PTW_REQ, PTW_WAIT, WRITE, FAULT, DRAIN.
- IDLE:
  - miss_vld_i & miss_rdy_o latches miss_vpn_i, increments miss_cnt_o (holds at all-ones) and moves to VICTIM.
  - If flush_i is high in the same cycle, the miss is not accepted.
- VICTIM (1 cycle): plru_refill_rq_o=1, then go to PTW_REQ. flush_i -> IDLE.
- PTW_REQ:
  - ptw_req_vld_o=1 and ptw_req_vpn_o=latched VPN, both held stable until ptw_req_rdy_i.
  - On the first PTW_REQ cycle, plru_victim_onehot_i is latched into tlb_wr_onehot_o's register.
  - Handshake -> PTW_WAIT.
  - flush_i without a handshake -> IDLE, with ptw_req_vld_o dropped the next cycle.
  - flush_i with a handshake in the same cycle -> DRAIN.
- PTW_WAIT:
  - ptw_resp_vld_i latches ppn/perm; fault=0 -> WRITE, fault=1 -> FAULT.
  - flush_i with no response -> DRAIN; flush_i with a response in the same cycle -> response discarded, go to IDLE.
- WRITE (1 cycle):
  - tlb_wr_en_o=1, plru_refill_vld_o=1, refill_done_o=1, then go to IDLE.
  - tlb_wr_vpn/ppn/perm/onehot carry the latched values.
  - If flush_i is high, all three strobes are suppressed and the state still goes to IDLE.
- FAULT (1 cycle): refill_fault_o=1, with no TLB write and no plru_refill_vld_o, then go to IDLE. flush_i suppresses the pulse.
- DRAIN: wait for ptw_resp_vld_i, discard the response, go to IDLE. No outputs; busy_o=1; further flush_i has no effect.
- ptw_resp_vld_i outside PTW_WAIT/DRAIN is ignored.
- Exactly one PTW request is outstanding at any time.
- Minimum miss-to-done latency with rdy=1 and the response one cycle after the handshake:
  - accept at cycle 0, VICTIM at 1, REQ+handshake at 2, response at 3, WRITE/done at 4.
  - The next miss can be accepted at cycle 5.
- miss_cnt_o is cleared only by reset.

Test Plan:
1. Basic refill: VPN 0x1234 accepted at c0, PLRU onehot 0x00000100, rdy=1, response PPN 0xABC/perm 0xCB at c3 -> c4: tlb_wr_en=1, onehot 0x100, VPN 0x1234, PPN 0xABC, refill_done=1, plru_refill_vld=1; c5 miss_rdy=1.
2. PTW backpressure: ptw_req_rdy_i low for 5 cycles -> ptw_req_vld_o held high with VPN stable all 6 cycles; state enters PTW_WAIT only after the handshake.
3. Fault: response with fault=1 -> refill_fault_o single pulse; tlb_wr_en_o, plru_refill_vld_o and refill_done_o stay 0.
4. Flush in PTW_WAIT: flush at c3 with the response at c7 (PPN 0x55) -> DRAIN until c7, IDLE at c8; no write and no pulses. Repeat with flush and handshake in the same cycle -> DRAIN.
5. Flush and miss together in IDLE -> miss not accepted, miss_cnt unchanged; next-cycle miss accepted.
6. Counter/reset: preload via 65535 misses -> miss_cnt=0xFFFF holds on the next miss. Assert rst_i during PTW_WAIT -> next cycle IDLE, all outputs 0, miss_cnt=0.
